// File: rtl/adc_cfg_seq.sv
// adc_cfg_seq: JTAG-loaded ADC config table replayed serially to a masked set of ADCs
module adc_cfg_seq #(
  parameter int NADC      = 12,
  parameter int DW        = 24,
  parameter int AW        = 4,
  parameter int SCLK_DIV  = 2,
  parameter int AUTO_INIT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [AW:0]     num_i,
  input  logic [NADC-1:0] mask_i,
  input  logic            init_i,
  output logic [NADC-1:0] cs_o,
  output logic            sclk_o,
  output logic            sdata_o,
  output logic            busy_o,
  output logic            done_o
);
  localparam int CW = $clog2(SCLK_DIV) + 1;
  localparam int BW = $clog2(DW) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, GAP, FIN} state_t;
  state_t state_q, state_d;
  logic [DW-1:0]   mem [2**AW];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            hi_q, hi_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     nrem_q, nrem_d;
  logic [NADC-1:0] msk_q, msk_d, msk_sel;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            auto_q, auto_d;
  logic [NADC-1:0] cs_q, cs_d;
  logic            sclk_q, sclk_d, sdata_q, sdata_d, done_q, done_d;
  logic            start, last, act;
  assign start   = init_i || (AUTO_INIT != 0 && auto_q);
  assign msk_sel = (AUTO_INIT != 0 && auto_q) ? '1 : mask_i;
  assign last    = cnt_q == CW'(SCLK_DIV - 1);
  assign act     = state_q inside {SETUP, SHIFT, HOLD};
  assign busy_o  = state_q != IDLE;
  assign cs_o    = cs_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;
  assign done_o  = done_q;
  // Table write port; blocked for the whole replay so the words being sent stay stable
  always_ff @(posedge clk_i)
    if (we_i && state_q == IDLE) mem[waddr_i] <= wdata_i;
  // Sequencer registers; the auto-start flag re-arms on every reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      idx_q   <= '0;
      nrem_q  <= '0;
      msk_q   <= '0;
      shreg_q <= '0;
      auto_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      nrem_q  <= nrem_d;
      msk_q   <= msk_d;
      shreg_q <= shreg_d;
      auto_q  <= auto_d;
    end
  end
  // Next state: phase counter runs in every timed state, bits shift after each high phase
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q inside {SETUP, SHIFT, HOLD, GAP} && !last) ? cnt_q + CW'(1) : '0;
    bit_d   = bit_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    nrem_d  = nrem_q;
    msk_d   = msk_q;
    shreg_d = shreg_q;
    auto_d  = auto_q;
    case (state_q)
      IDLE: if (start) begin
        nrem_d  = num_i;
        msk_d   = msk_sel;
        idx_d   = '0;
        auto_d  = 1'b0;
        state_d = (num_i == '0 || msk_sel == '0) ? FIN : LOAD;
      end
      LOAD: begin
        shreg_d = mem[idx_q];
        bit_d   = '0;
        hi_d    = 1'b0;
        state_d = SETUP;
      end
      SETUP: state_d = last ? SHIFT : SETUP;
      SHIFT: if (last) begin
        hi_d = ~hi_q;
        if (hi_q && bit_q == BW'(DW - 1)) state_d = HOLD;
        else if (hi_q) begin
          bit_d   = bit_q + BW'(1);
          shreg_d = {shreg_q[DW-2:0], 1'b0};
        end
      end
      HOLD: state_d = last ? GAP : HOLD;
      GAP: if (last) begin
        idx_d   = idx_q + AW'(1);
        nrem_d  = nrem_q - (AW+1)'(1);
        state_d = (nrem_q == (AW+1)'(1)) ? FIN : LOAD;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Pin values derived from the current state, registered so the pins are glitch free
  always_comb begin
    cs_d    = act ? ~msk_q : '1;
    sclk_d  = state_q == SHIFT && hi_q;
    sdata_d = act && shreg_q[DW-1];
    done_d  = state_q == FIN;
  end
  // Pin registers reset directly so an abort idles the bus on the reset edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_q    <= '1;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_adc_cfg_seq.sv
// tb_adc_cfg_seq: randomized replay runs checked by a serial-bus frame scoreboard
module tb_adc_cfg_seq;
  localparam int NADC  = 12;
  localparam int DW    = 24;
  localparam int AW    = 4;
  localparam int SD    = 2;
  localparam int PW    = 1 + (2*DW + 3)*SD;
  localparam int CSLEN = (2*DW + 2)*SD;
  typedef struct {logic [NADC-1:0] cs; logic [DW-1:0] w;} frame_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst_a, we, init;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW:0] num, num_a;
  logic [NADC-1:0] mask, cs, cs_a;
  logic sclk, sdata, busy, done, sclk_a, sdata_a, busy_a, done_a;
  int vecs = 0, errs = 0;
  logic [DW-1:0] model [2**AW];
  frame_t exp_q[$];
  adc_cfg_seq #(.NADC(NADC), .DW(DW), .AW(AW), .SCLK_DIV(SD), .AUTO_INIT(0)) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .num_i(num),
    .mask_i(mask), .init_i(init), .cs_o(cs), .sclk_o(sclk), .sdata_o(sdata),
    .busy_o(busy), .done_o(done));
  adc_cfg_seq #(.NADC(NADC), .DW(DW), .AW(AW), .SCLK_DIV(SD), .AUTO_INIT(1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .num_i(num_a),
    .mask_i(mask), .init_i(1'b0), .cs_o(cs_a), .sclk_o(sclk_a), .sdata_o(sdata_a),
    .busy_o(busy_a), .done_o(done_a));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask
  // Frame monitor: rebuilds each CS-low frame from SCLK rising edges and scores it
  logic m_act, m_ps;
  logic [NADC-1:0] m_cs;
  logic [DW-1:0] m_w;
  int m_nb, m_len;
  initial begin
    m_act = 1'b0; m_ps = 1'b0; m_cs = '1; m_w = '0; m_nb = 0; m_len = 0;
    forever begin
      @(negedge clk);
      if (cs !== '1) begin
        if (!m_act) begin
          m_act = 1'b1; m_cs = cs; m_w = '0; m_nb = 0; m_len = 0;
        end
        m_len++;
        if (sclk && !m_ps) begin
          m_w = {m_w[DW-2:0], sdata};
          m_nb++;
        end
      end else begin
        if (sclk && !m_ps) begin
          vecs++; errs++;
          $display("FAIL stray_sclk: got SCLK edge with CS idle expected none");
        end
        if (m_act) begin
          m_act = 1'b0;
          if (!rst) begin
            if (exp_q.size() == 0) begin
              vecs++; errs++;
              $display("FAIL frame_unexpected: got frame cs=%0h expected no frame", m_cs);
            end else begin
              frame_t e;
              e = exp_q.pop_front();
              chk("frame_word", m_w, e.w);
              chk("frame_cs", m_cs, e.cs);
              chk("frame_bits", m_nb, DW);
              chk("frame_len", m_len, CSLEN);
            end
          end
        end
      end
      m_ps = sclk;
    end
  end
  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    we = 1'b1; waddr = AW'(a); wdata = d; model[a] = d;
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic run(input int n, input logic [NADC-1:0] m, input bit disturb, input bit we_start);
    int off, tgt, first_cs;
    tgt = (n > 0 && m != '0) ? n*PW + 1 : 1;
    first_cs = -1;
    @(negedge clk);
    num = (AW+1)'(n); mask = m; init = 1'b1;
    if (we_start) begin
      we = 1'b1; waddr = '0; wdata = DW'($urandom); model[0] = wdata;
    end
    if (n > 0 && m != '0)
      for (int i = 0; i < n; i++) exp_q.push_back(frame_t'{cs: ~m, w: model[i]});
    @(negedge clk);
    init = 1'b0; we = 1'b0;
    chk("busy_start", busy, 1);
    off = 0;
    while (off <= tgt + 20) begin
      if (cs !== '1 && first_cs < 0) first_cs = off;
      if (done) break;
      if (disturb) begin
        init = (off % 50 == 7) && (off + 5 < tgt);
        we = (off % 50 == 30) && (off + 5 < tgt);
        waddr = '0; wdata = DW'($urandom);
      end
      @(negedge clk);
      off++;
    end
    init = 1'b0; we = 1'b0;
    chk("done_cycle", off, tgt);
    chk("busy_at_done", busy, 0);
    chk("first_cs", first_cs, (n > 0 && m != '0) ? 2 : -1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  initial begin
    int off, dn, don, lowc, nb;
    logic ps;
    logic [2*DW-1:0] aw;
    logic [NADC-1:0] rm;
    rst = 1'b1; rst_a = 1'b1; we = 1'b0; init = 1'b0; waddr = '0; wdata = '0;
    num = '0; mask = '0; num_a = (AW+1)'(2);
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, {NADC{1'b1}});
    chk("rst_sclk", sclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    for (int i = 0; i < 2**AW; i++) wr(i, DW'($urandom));
    wr(0, 24'hA5F00F);
    run(1, 12'h001, 0, 0);
    wr(0, 24'h000001); wr(1, 24'h800000); wr(2, 24'h555555);
    run(3, 12'hFFF, 0, 0);
    run(0, 12'hFFF, 0, 0);
    run(2, 12'h000, 0, 0);
    @(negedge clk);
    num = (AW+1)'(3); mask = 12'hFFF; init = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(frame_t'{cs: 12'h000, w: model[i]});
    @(negedge clk);
    init = 1'b0;
    repeat (PW + 1 + SD + 10*2*SD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs", cs, {NADC{1'b1}});
    chk("abort_sclk", sclk, 0);
    chk("abort_sdata", sdata, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run(3, 12'hFFF, 0, 0);
    rm = NADC'($urandom) | 12'h010;
    run(2, rm, 1, 0);
    run(1, NADC'($urandom) | 12'h001, 0, 0);
    run(1, NADC'($urandom) | 12'h800, 0, 1);
    for (int k = 0; k < 3; k++) run($urandom_range(1, 4), NADC'($urandom), 0, 0);
    run(16, 12'hFFF, 0, 0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    dn = 0; don = -1; lowc = 0; nb = 0; ps = 1'b0; aw = '0;
    for (off = 0; off < 600; off++) begin
      if (done_a) begin
        dn++;
        if (don < 0) don = off;
      end
      if (cs_a === '0) lowc++;
      if (sclk_a && !ps) begin
        aw = {aw[2*DW-2:0], sdata_a};
        nb++;
      end
      ps = sclk_a;
      @(negedge clk);
    end
    chk("auto_done_count", dn, 1);
    chk("auto_done_cycle", don, 2*PW + 1);
    chk("auto_cs_all_low", lowc, 2*CSLEN);
    chk("auto_bits", nb, 2*DW);
    chk("auto_words", aw, {model[0], model[1]});
    chk("auto_idle", busy_a, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
